// File: rtl/ras_ckpt_stack.sv
// ras_ckpt_stack: checkpointable return-address stack.
//
// Circular stack of RAS_DEPTH return targets. Calls push, returns pop, and a
// mispredict restore reloads the top pointer and occupancy from a checkpoint
// without touching the stored targets. A push into a full stack wraps and
// overwrites the oldest entry.
//
// Optional feature macro: RAS_RESTORE_EN
//   defined   -> update_valid restores ras_index/ras_count and blocks
//                same-cycle push/pop.
//   undefined -> update_* inputs are ignored; push/pop always proceed.
//
// Ports:
//   CLK              in   clock, rising-edge state updates
//   RST              in   asynchronous active-high reset
//   link_valid       in   push request (call)
//   link_target      in   return target to push
//   ret_valid        in   pop request (return)
//   update_valid     in   restore request (mispredict)
//   update_ras_index in   checkpointed top pointer
//   update_ras_count in   checkpointed occupancy (clamped to RAS_DEPTH)
//   ret_target       out  predicted return target, stack[ras_index]
//   ras_index        out  current top pointer
//   ras_count        out  current occupancy
//   ras_empty        out  high when ras_count == 0
module ras_ckpt_stack #(
  parameter  int RAS_DEPTH        = 8,
  parameter  int RAS_TARGET_WIDTH = 10,
  localparam int LOG_RAS_DEPTH    = $clog2(RAS_DEPTH)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        link_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] link_target,
  input  logic                        ret_valid,
  input  logic                        update_valid,
  input  logic [LOG_RAS_DEPTH-1:0]    update_ras_index,
  input  logic [LOG_RAS_DEPTH:0]      update_ras_count,
  output logic [RAS_TARGET_WIDTH-1:0] ret_target,
  output logic [LOG_RAS_DEPTH-1:0]    ras_index,
  output logic [LOG_RAS_DEPTH:0]      ras_count,
  output logic                        ras_empty
);

  localparam logic [LOG_RAS_DEPTH:0]   FULL_CNT = (LOG_RAS_DEPTH+1)'(RAS_DEPTH);
  localparam logic [LOG_RAS_DEPTH:0]   ZERO_CNT = {(LOG_RAS_DEPTH+1){1'b0}};
  localparam logic [LOG_RAS_DEPTH:0]   ONE_CNT  = (LOG_RAS_DEPTH+1)'(1);
  localparam logic [LOG_RAS_DEPTH-1:0] ONE_IDX  = (LOG_RAS_DEPTH)'(1);

  logic [RAS_TARGET_WIDTH-1:0] stack_q [RAS_DEPTH];
  logic [LOG_RAS_DEPTH-1:0]    index_q, index_d;
  logic [LOG_RAS_DEPTH:0]      count_q, count_d;
  logic                        wr_en_s;
  logic [LOG_RAS_DEPTH-1:0]    wr_idx_s;
  logic                        restore_s;

`ifdef RAS_RESTORE_EN
  assign restore_s = update_valid;
`else
  // Restore inputs stay on the port list but have no effect in this build.
  logic unused_update_s;
  assign unused_update_s = ^{update_valid, update_ras_index, update_ras_count};
  assign restore_s       = 1'b0;
`endif

  // Zero-latency prediction straight from the current top entry.
  assign ret_target = stack_q[index_q];
  assign ras_index  = index_q;
  assign ras_count  = count_q;
  assign ras_empty  = (count_q == ZERO_CNT);

  // Next-state pointer/occupancy and the single stack write port.
  always_comb begin
    index_d  = index_q;
    count_d  = count_q;
    wr_en_s  = 1'b0;
    wr_idx_s = index_q;
    if (restore_s) begin
      // Restore wins over same-cycle push/pop and never writes the stack.
      index_d = update_ras_index;
      count_d = (update_ras_count > FULL_CNT) ? FULL_CNT : update_ras_count;
    end else if (link_valid && ret_valid) begin
      // Call and return together replace the top entry in place.
      wr_en_s = 1'b1;
      count_d = (count_q == ZERO_CNT) ? ONE_CNT : count_q;
    end else if (link_valid) begin
      index_d  = index_q + ONE_IDX;
      wr_en_s  = 1'b1;
      wr_idx_s = index_q + ONE_IDX;
      count_d  = (count_q == FULL_CNT) ? FULL_CNT : (count_q + ONE_CNT);
    end else if (ret_valid) begin
      // Popping an empty stack leaves everything as it was.
      if (count_q != ZERO_CNT) begin
        index_d = index_q - ONE_IDX;
        count_d = count_q - ONE_CNT;
      end else begin
        index_d = index_q;
        count_d = count_q;
      end
    end else begin
      index_d = index_q;
      count_d = count_q;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      index_q <= {LOG_RAS_DEPTH{1'b0}};
      count_q <= ZERO_CNT;
    end else begin
      index_q <= index_d;
      count_q <= count_d;
    end
  end

  // Stack storage; reset clears every entry so no stale target survives.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        stack_q[i] <= {RAS_TARGET_WIDTH{1'b0}};
      end
    end else if (wr_en_s) begin
      stack_q[wr_idx_s] <= link_target;
    end else begin
      stack_q[wr_idx_s] <= stack_q[wr_idx_s];
    end
  end

endmodule

// File: tb/tb_ras_ckpt_stack.sv
// Self-checking bench for ras_ckpt_stack (RAS_DEPTH=8, RAS_TARGET_WIDTH=10).
// A plain-integer reference model of the stack is compared against the DUT on
// every falling clock edge; directed scenarios add literal expectations.
module tb_ras_ckpt_stack;

  localparam int D = 8;
`ifdef RAS_RESTORE_EN
  localparam bit RESTORE = 1'b1;
`else
  localparam bit RESTORE = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       link_valid = 1'b0;
  logic [9:0] link_target = 10'd0;
  logic       ret_valid = 1'b0;
  logic       update_valid = 1'b0;
  logic [2:0] update_ras_index = 3'd0;
  logic [3:0] update_ras_count = 4'd0;
  logic [9:0] ret_target;
  logic [2:0] ras_index;
  logic [3:0] ras_count;
  logic       ras_empty;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // Reference model: plain integers, circular index arithmetic.
  int m_stack [D];
  int m_idx;
  int m_cnt;

  ras_ckpt_stack #(.RAS_DEPTH(8), .RAS_TARGET_WIDTH(10)) dut (
    .CLK(CLK), .RST(RST),
    .link_valid(link_valid), .link_target(link_target),
    .ret_valid(ret_valid),
    .update_valid(update_valid), .update_ras_index(update_ras_index),
    .update_ras_count(update_ras_count),
    .ret_target(ret_target), .ras_index(ras_index),
    .ras_count(ras_count), .ras_empty(ras_empty)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < D; i++) m_stack[i] = 0;
    m_idx = 0;
    m_cnt = 0;
  endfunction

  function automatic void model_step(input bit lv, input int lt, input bit rv,
                                     input bit uv, input int ui, input int uc);
    if (RESTORE && uv) begin
      m_idx = ui;
      m_cnt = (uc > D) ? D : uc;
    end else if (lv && rv) begin
      m_stack[m_idx] = lt;
      if (m_cnt == 0) m_cnt = 1;
    end else if (lv) begin
      m_idx = (m_idx + 1) % D;
      m_stack[m_idx] = lt;
      if (m_cnt < D) m_cnt = m_cnt + 1;
    end else if (rv && m_cnt > 0) begin
      m_idx = (m_idx + D - 1) % D;
      m_cnt = m_cnt - 1;
    end
  endfunction

  // Continuous comparison of every output against the model.
  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("ret_target", int'(ret_target), m_stack[m_idx]);
      chk("ras_index",  int'(ras_index),  m_idx);
      chk("ras_count",  int'(ras_count),  m_cnt);
      chk("ras_empty",  int'(ras_empty),  (m_cnt == 0) ? 1 : 0);
    end
  end

  // One clock of stimulus; returns on the following falling edge.
  task automatic step(input bit lv, input int lt, input bit rv,
                      input bit uv, input int ui, input int uc);
    link_valid       = lv;
    link_target      = 10'(lt);
    ret_valid        = rv;
    update_valid     = uv;
    update_ras_index = 3'(ui);
    update_ras_count = 4'(uc);
    @(posedge CLK);
    #1;
    model_step(lv, lt, rv, uv, ui, uc);
    @(negedge CLK);
  endtask

  task automatic push(input int t);  step(1'b1, t, 1'b0, 1'b0, 0, 0); endtask
  task automatic pop();              step(1'b0, 0, 1'b1, 1'b0, 0, 0); endtask
  task automatic idle();             step(1'b0, 0, 1'b0, 1'b0, 0, 0); endtask

  // Reset for a full cycle, then release right after a falling edge so the
  // next stimulus lands on the first rising edge out of reset.
  task automatic do_reset();
    #2;
    RST = 1'b1;
    model_reset();
    link_valid = 1'b0; ret_valid = 1'b0; update_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    int seen;
    model_reset();
    @(negedge CLK);
    cmp_en = 1'b1;
    @(negedge CLK);
    #1;
    // Reset state held.
    chk("rst_ret_target", int'(ret_target), 0);
    chk("rst_empty", int'(ras_empty), 1);
    RST = 1'b0;

    // Three pushes straight out of reset.
    push(10'h011); push(10'h022); push(10'h033);
    chk("p3_ret_target", int'(ret_target), 10'h033);
    chk("p3_index", int'(ras_index), 3);
    chk("p3_count", int'(ras_count), 3);
    chk("p3_empty", int'(ras_empty), 0);
    idle();

    // Overflow by one, then drain past empty.
    do_reset();
    for (int k = 1; k <= 9; k++) push(k);
    chk("ovf_count", int'(ras_count), 8);
    chk("ovf_index", int'(ras_index), 1);
    for (int k = 0; k < 8; k++) begin
      seen = int'(ret_target);
      chk("drain_target", seen, 9 - k);
      pop();
    end
    chk("drain_count", int'(ras_count), 0);
    chk("drain_empty", int'(ras_empty), 1);
    chk("drain_index", int'(ras_index), 1);
    pop();
    chk("empty_pop_index", int'(ras_index), 1);
    chk("empty_pop_target", int'(ret_target), 10'h009);

    // Simultaneous push and pop replaces the top in place.
    do_reset();
    push(10'h099); push(10'h0AA);
    chk("pp_pre_target", int'(ret_target), 10'h0AA);
    step(1'b1, 10'h0BB, 1'b1, 1'b0, 0, 0);
    chk("pp_target", int'(ret_target), 10'h0BB);
    chk("pp_index", int'(ras_index), 2);
    chk("pp_count", int'(ras_count), 2);
    // Push+pop on an empty stack sets count to one.
    do_reset();
    step(1'b1, 10'h155, 1'b1, 1'b0, 0, 0);
    chk("pp_empty_count", int'(ras_count), 1);
    chk("pp_empty_index", int'(ras_index), 0);

    // Checkpoint at index 2 / count 2, run ahead, then restore with a push.
    do_reset();
    push(10'h011); push(10'h022);
    push(10'h3FF);
    pop(); pop();
    step(1'b1, 10'h111, 1'b0, 1'b1, 2, 2);
`ifdef RAS_RESTORE_EN
    chk("rest_index", int'(ras_index), 2);
    chk("rest_count", int'(ras_count), 2);
    chk("rest_target", int'(ret_target), 10'h022);
    // Restore with an out-of-range count clamps to full.
    step(1'b0, 0, 1'b0, 1'b1, 5, 12);
    chk("clamp_count", int'(ras_count), 8);
    chk("clamp_index", int'(ras_index), 5);
`else
    chk("norest_index", int'(ras_index), 2);
    chk("norest_count", int'(ras_count), 2);
    chk("norest_target", int'(ret_target), 10'h111);
    // update with index 5 alongside a push: the push still happens.
    step(1'b1, 10'h2C3, 1'b0, 1'b1, 5, 4);
    chk("norest_push_index", int'(ras_index), 3);
    chk("norest_push_target", int'(ret_target), 10'h2C3);
`endif

    // Asynchronous reset between edges with five entries live.
    do_reset();
    for (int k = 0; k < 5; k++) push(10'h040 + k);
    chk("pre_arst_count", int'(ras_count), 5);
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    chk("arst_target", int'(ret_target), 0);
    chk("arst_index", int'(ras_index), 0);
    chk("arst_count", int'(ras_count), 0);
    chk("arst_empty", int'(ras_empty), 1);
    @(negedge CLK);
    #1;
    RST = 1'b0;
    // First edge after release honours the push.
    push(10'h3A5);
    chk("post_rst_target", int'(ret_target), 10'h3A5);
    chk("post_rst_count", int'(ras_count), 1);
    idle();

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ras_ckpt_stack.md
RAS_CKPT_STACK -- requirements
Module: ras_ckpt_stack

Interface
REQ-001 SHALL have parameter RAS_DEPTH, default 8: stack entries; power of two, >= 2.
REQ-002 SHALL have parameter RAS_TARGET_WIDTH, default 10: width of each stored return target.
REQ-003 SHALL derive LOG_RAS_DEPTH = $clog2(RAS_DEPTH) internally; it is not overridable.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port CLK  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port RST  input  1  asynchronous active-high reset.
REQ-007 SHALL have port link_valid  input  1  push request (call).
REQ-008 SHALL have port link_target  input  RAS_TARGET_WIDTH  return target to push.
REQ-009 SHALL have port ret_valid  input  1  pop request (return).
REQ-010 SHALL have port update_valid  input  1  restore request from mispredict.
REQ-011 SHALL have port update_ras_index  input  LOG_RAS_DEPTH  checkpointed pointer.
REQ-012 SHALL have port update_ras_count  input  LOG_RAS_DEPTH+1  checkpointed occupancy.
REQ-013 SHALL have port ret_target  output  RAS_TARGET_WIDTH  predicted return target.
REQ-014 SHALL have port ras_index  output  LOG_RAS_DEPTH  current top pointer, for checkpointing.
REQ-015 SHALL have port ras_count  output  LOG_RAS_DEPTH+1  current occupancy, for checkpointing.
REQ-016 SHALL have port ras_empty  output  1  high when ras_count == 0.

Function
REQ-017 SHALL drive ret_target combinationally as stack[ras_index], with zero latency.
REQ-018 On a push only, SHALL write link_target to stack[ras_index+1 mod RAS_DEPTH], increment the pointer, and saturate the count at RAS_DEPTH.
REQ-019 On a push while full, SHALL wrap the pointer and overwrite the oldest entry, holding the count at RAS_DEPTH.
REQ-020 On a pop only with count > 0, SHALL decrement the pointer mod RAS_DEPTH and decrement the count.
REQ-021 On a pop only while empty, SHALL leave the pointer, count and stack unchanged; ret_target remains the stale stack[ras_index].
REQ-022 On a simultaneous push and pop, SHALL overwrite stack[ras_index] with link_target, keep the pointer, and set count = max(count,1).
REQ-023 The update path SHALL take priority: when update_valid=1, ras_index <= update_ras_index and ras_count <= update_ras_count, and the same-cycle push/pop SHALL be ignored.
REQ-024 An update SHALL NOT modify stack contents.
REQ-025 update_ras_count values > RAS_DEPTH SHALL be clamped to RAS_DEPTH.
REQ-026 With all requests low, SHALL hold all state.

Reset
REQ-027 Asserting RST SHALL immediately clear all stack entries, ras_index and ras_count to 0, regardless of CLK.
REQ-028 During reset SHALL output ret_target=0, ras_index=0, ras_count=0 and ras_empty=1.
REQ-029 Requests present on the first edge after RST deasserts SHALL be honoured normally.
REQ-030 Reset asserted mid-operation SHALL discard all pending state; no partial push survives.

Configuration
REQ-031 The restore feature SHALL be controlled by macro RAS_RESTORE_EN.
REQ-032 With RAS_RESTORE_EN defined, SHALL implement REQ-023 to REQ-025.
REQ-033 Without RAS_RESTORE_EN, update_valid, update_ras_index and update_ras_count SHALL be present but ignored, and push/pop SHALL always proceed.

Verification (RAS_DEPTH=8, RAS_TARGET_WIDTH=10)
REQ-034 Reset, then push 0x011, 0x022, 0x033 -> ret_target=0x033, ras_index=3, ras_count=3, ras_empty=0.
REQ-035 Push 9 targets 0x001..0x009 from reset, then pop 8 times -> targets seen 0x009 down to 0x002, ras_count=0, ras_empty=1; a 9th pop leaves ras_index unchanged.
REQ-036 With count=2 and top=0x0AA, assert push 0x0BB and pop together -> ret_target=0x0BB, ras_index unchanged, ras_count=2.
REQ-037 Checkpoint index=2/count=2, push 0x3FF, pop twice, then update_valid with a same-cycle push 0x111 -> ras_index=2, ras_count=2, ret_target=the original stack[2]; 0x111 is not written.
REQ-038 Assert RST asynchronously between edges with count=5 -> outputs are 0/0/0 and ras_empty=1 before the next CLK edge.
REQ-039 Build without RAS_RESTORE_EN; assert update_valid=1 with index=5 alongside a push -> the push occurs and ras_index=old+1.
